mem_align_unit: RTL and testbench
=================================

# mem_align_unit

Parametrised big-endian load/store alignment unit between the pipeline's MEM stage and a word-wide data memory without byte strobes. It extracts and sign/zero-extends byte, halfword, word (and doubleword at 64-bit width) loads. It performs sub-word stores as a read-modify-write sequence. It is the sequenced, width-generic successor of the combinational byte insert/extract logic.

## Interface
- `DATA_W`, 32: memory/data width; 32 or 64. `NB = DATA_W/8` byte lanes; `OFS_W = log2(NB)`.
- `ADDR_W`, 32: byte address width.
- `clk` in 1: clock.
- `rst` in 1: reset; one clock, asynchronous, active-high.
- `req_valid` in 1: access request.
- `req_ready` out 1: unit idle and accepting.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 dword.
- `req_signed` in 1: sign-extend a load.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store value, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out DATA_W: extended load data; 0 for stores.
- `resp_err` out 1: access rejected; no memory access made.
- `mem_en` out 1: memory cycle request, held until ack.
- `mem_we` out 1: write qualifier.
- `mem_addr` out ADDR_W: lane-aligned address, low OFS_W bits zero.
- `mem_wdata` out DATA_W: full-word write data.
- `mem_rdata` in DATA_W: read data, valid with ack.
- `mem_ack` in 1: completes the current memory cycle. It may arrive in the same cycle as `mem_en` or any later cycle.

## Operation
- Big-endian lane mapping: the byte at offset k (`addr[OFS_W-1:0]`) occupies bits `[DATA_W-1-8k -: 8]`. A half at offset k occupies lanes k and k+1.
- Size legality: dword with DATA_W=32 is always an error. Size wider than DATA_W is always an error.
- State machine:
  - IDLE: `req_ready=1`. On accept, the request is registered.
    - Error → RESP.
    - Load or sub-word store → RD.
    - Full-width store → WR.
  - RD: `mem_en=1`, `mem_we=0`. On `mem_ack`, `mem_rdata` is captured.
    - Load → RESP.
    - Sub-word store → WR, with the new lanes merged into the captured word. All other lanes are preserved.
  - WR: `mem_en=1`, `mem_we=1`, `mem_wdata` is the merged or full word. On `mem_ack` → RESP.
  - RESP: `resp_valid=1` for one cycle → IDLE. There is no response backpressure.
- Load extraction: the selected lanes are right-justified. Upper bits are the MSB of the field if `req_signed`, else 0. `req_signed` is ignored for full-width loads.
- `mem_ack` is ignored in IDLE and RESP.
- `req_*` inputs are sampled only at acceptance. Later changes have no effect.
- Reset values: state IDLE, `req_ready=1`, all other outputs 0.
- Reset mid-operation:
  - `mem_en`/`mem_we` drop asynchronously.
  - The operation is abandoned with no response.
  - A partially completed RMW leaves memory unmodified, because a write only happens in WR.

## Timing
- Accept at cycle 0. Memory cycle starts at cycle 1.
- Zero-wait memory (ack in the same cycle as `mem_en`):
  - Load: `resp_valid` at cycle 2.
  - Full store: `resp_valid` at cycle 2.
  - Sub-word store: `resp_valid` at cycle 3.
  - Error: `resp_valid` at cycle 1.
- Each memory wait cycle adds one cycle.
- Throughput: one request in flight. `req_ready` rises in the cycle after RESP, so a new accept can occur at the earliest at resp cycle + 1.
- All outputs are registered or decoded from state. There is no combinational path from `req_*` to `mem_*`.

## Configuration
- `MEM_ALIGN_TRAP_EN` defined: a misaligned access (offset not a multiple of the access size) returns `resp_err=1`, makes no memory access, and has `resp_rdata=0`.
- `MEM_ALIGN_TRAP_EN` undefined: the offset bits below the access size are forced to zero and the access proceeds aligned. `resp_err` is asserted only for illegal sizes.

## Structure
- Package `mem_pkg`:
  - Size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_DWORD`).
  - State enum (`S_IDLE`, `S_RD`, `S_WR`, `S_RESP`).
  - Size-to-byte-count function.
- Sub-module `lane_op`: combinational, parametrised by DATA_W. It provides `extract(word, offset, size, signed)` and `insert(word, offset, size, value)`. It is instantiated once for the load path and once for the merge path.

## Test plan
- LB at offset 1 over mem word 0x12F45678, `req_signed=1` → `resp_rdata=0xFFFFFFF4`; repeated with `req_signed=0` → 0x000000F4.
- SB value 0xAB at offset 2 over 0x11223344 → one read, then a write of `mem_wdata=0x1122AB44`, `resp_valid` at cycle 3 with zero-wait memory.
- SH 0xBEEF at offset 2 over 0x11223344 → write 0x1122BEEF. LH signed at offset 0 over 0x80017777 → 0xFFFF8001.
- LW at address 0x1002: with `MEM_ALIGN_TRAP_EN` → `resp_err=1` at cycle 1 and `mem_en` never high. Without it → `mem_addr=0x1000` and the full word is returned.
- `mem_ack` delayed 3 cycles with `req_valid` held high → `req_ready` stays low until after `resp_valid`. The second request is accepted exactly one cycle after the first response.
- `rst` asserted during WR before ack → `mem_en` low in the same cycle, no `resp_valid`, memory contents unchanged, and `req_ready=1` after reset release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the big-endian load/store alignment unit:
// size encodings, controller states and the size-to-byte-count helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  function automatic int size_bytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

endpackage

// File: rtl/mem_align_unit_if.sv
// Request/response and memory-side bus of mem_align_unit.
// slave = the alignment unit's view, master = the pipeline/memory side.
interface mem_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_align_unit_lane_op.sv
// Combinational big-endian lane extract (right-justify + extend) or insert
// (merge value into the addressed lanes), selected by op_insert_i.
module lane_op
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFS_W  = $clog2(NB)
) (
  input  logic              op_insert_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [OFS_W-1:0]  ofs_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] value_i,
  output logic [DATA_W-1:0] result_o
);

  int                n;
  int                k;
  int                sh;
  logic [DATA_W-1:0] low_mask;
  logic [DATA_W-1:0] field;
  logic              msb;

  always_comb begin
    n = size_bytes(size_i);
    if (n > NB) n = NB;
    k = int'(ofs_i);
    // Clamp so shifts stay in range for combinations the controller never uses.
    if (k + n > NB) k = NB - n;
    sh       = 8 * (NB - k - n);
    low_mask = (n >= NB) ? '1 : ((DATA_W'(1) << (8 * n)) - DATA_W'(1));
    field    = (word_i >> sh) & low_mask;
    msb      = |(field & (low_mask ^ (low_mask >> 1)));
    if (op_insert_i) begin
      result_o = (word_i & ~(low_mask << sh)) | ((value_i & low_mask) << sh);
    end else begin
      result_o = field | ((signed_i && msb) ? ~low_mask : '0);
    end
  end

endmodule

// File: rtl/mem_align_unit.sv
// Sequenced big-endian load/store alignment unit; sub-word stores are done as
// read-modify-write. Define MEM_ALIGN_TRAP_EN to reject misaligned accesses.
module mem_align_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst,
  mem_align_unit_if.slave  bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);

  state_e            state_q, state_d;
  logic              we_q, signed_q, err_q;
  logic [1:0]        size_q;
  logic [OFS_W-1:0]  ofs_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, word_q, rdata_q;

  int                acc_n;
  logic [OFS_W-1:0]  acc_mask, acc_ofs;
  logic              acc_err, acc_full;
  logic [DATA_W-1:0] load_word, merge_word;

  always_comb begin
    acc_n    = size_bytes(bus.req_size);
    acc_mask = OFS_W'(acc_n - 1);
    acc_full = (acc_n == NB);
`ifdef MEM_ALIGN_TRAP_EN
    acc_err  = (acc_n > NB) || ((bus.req_addr[OFS_W-1:0] & acc_mask) != '0);
    acc_ofs  = bus.req_addr[OFS_W-1:0];
`else
    acc_err  = (acc_n > NB);
    acc_ofs  = bus.req_addr[OFS_W-1:0] & ~acc_mask;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        if (acc_err)                     state_d = S_RESP;
        else if (bus.req_we && acc_full) state_d = S_WR;
        else                             state_d = S_RD;
      end
      S_RD:    if (bus.mem_ack) state_d = we_q ? S_WR : S_RESP;
      S_WR:    if (bus.mem_ack) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      ofs_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (bus.req_valid) begin
          we_q     <= bus.req_we;
          signed_q <= bus.req_signed;
          err_q    <= acc_err;
          size_q   <= bus.req_size;
          ofs_q    <= acc_ofs;
          addr_q   <= bus.req_addr & ~ADDR_W'(NB - 1);
          wdata_q  <= bus.req_wdata;
          word_q   <= bus.req_wdata;
          rdata_q  <= '0;
        end
        // The read word is either the load result or the base of the RMW merge.
        S_RD: if (bus.mem_ack) begin
          if (we_q) word_q  <= merge_word;
          else      rdata_q <= load_word;
        end
        default: ;
      endcase
    end
  end

  lane_op #(.DATA_W(DATA_W)) u_load (
    .op_insert_i (1'b0),
    .word_i      (bus.mem_rdata),
    .ofs_i       (ofs_q),
    .size_i      (size_q),
    .signed_i    (signed_q),
    .value_i     ('0),
    .result_o    (load_word)
  );

  lane_op #(.DATA_W(DATA_W)) u_merge (
    .op_insert_i (1'b1),
    .word_i      (bus.mem_rdata),
    .ofs_i       (ofs_q),
    .size_i      (size_q),
    .signed_i    (1'b0),
    .value_i     (wdata_q),
    .result_o    (merge_word)
  );

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.mem_en     = (state_q == S_RD) || (state_q == S_WR);
  assign bus.mem_we     = (state_q == S_WR);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = (state_q == S_WR) ? word_q : '0;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_err   = (state_q == S_RESP) && err_q;
  assign bus.resp_rdata = (state_q == S_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_align_unit.sv
// Bench for mem_align_unit (DATA_W=32): directed cases plus random accesses
// checked against a byte-level big-endian memory model.
module tb_mem_align_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_align_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  mem_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] dev_mem [16];
  logic [31:0] ref_mem [16];
  int          n_rd = 0, n_wr = 0, n_en = 0;
  logic [31:0] last_addr = 0, last_wdata = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  int          n_pass = 0, n_total = 0;
  logic [31:0] last_rd;
  logic        last_err;
  int          last_lat;

  // Memory device: commits writes and counts cycles at the clock edge.
  always @(posedge clk) begin
    if (!rst && bus.mem_en) begin
      n_en++;
      if (bus.mem_ack) begin
        last_addr = bus.mem_addr;
        if (bus.mem_we) begin
          n_wr++;
          last_wdata = bus.mem_wdata;
          dev_mem[bus.mem_addr[5:2]] = bus.mem_wdata;
        end else begin
          n_rd++;
        end
      end
    end
  end

  // Ack after wait_cfg wait cycles, restarting the count for every memory cycle.
  always @(negedge clk) begin
    if (rst || !bus.mem_en) begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end else begin
      if (bus.mem_ack) wcnt = 0;
      if (wcnt >= wait_cfg) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = dev_mem[bus.mem_addr[5:2]];
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_word(input int i, input logic [31:0] w);
    dev_mem[i] = w;
    ref_mem[i] = w;
  endtask

  // Reference model: memory as big-endian byte lanes b[0] (MSB) .. b[3].
  task automatic model_req(input logic we, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd, input int wt,
                           output logic [31:0] erd, output logic eerr, output int elat);
    int          n, off, wi;
    logic [7:0]  b [4];
    logic [63:0] v;
    n    = 1 << sz;
    off  = int'(addr[1:0]);
    wi   = int'(addr[5:2]);
    erd  = 32'h0;
    eerr = 1'b0;
    elat = 1;
    if (n > 4) begin
      eerr = 1'b1;
      return;
    end
`ifdef MEM_ALIGN_TRAP_EN
    if (off % n != 0) begin
      eerr = 1'b1;
      return;
    end
`else
    off = off - off % n;
`endif
    for (int i = 0; i < 4; i++) b[i] = 8'((ref_mem[wi] >> (8 * (3 - i))) & 32'hFF);
    if (!we) begin
      v = 64'h0;
      for (int i = 0; i < n; i++) v = v * 256 + 64'(b[off + i]);
      if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
      erd  = v[31:0];
      elat = 2 + wt;
    end else begin
      for (int i = 0; i < n; i++) b[off + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
      ref_mem[wi] = {b[0], b[1], b[2], b[3]};
      elat = (n == 4) ? 2 + wt : 3 + 2 * wt;
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input int wt);
    int g;
    wait_cfg = wt;
    @(negedge clk);
    g = 0;
    while (!bus.req_ready && g < 100) begin @(negedge clk); g++; end
    check("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    last_lat = 0;
    do begin @(negedge clk); last_lat++; end while (!bus.resp_valid && last_lat < 100);
    last_rd  = bus.resp_rdata;
    last_err = bus.resp_err;
    $display("txn we=%0d sz=%0d sgn=%0d addr=%h wdata=%h wait=%0d -> rdata=%h err=%0d lat=%0d",
             we, sz, sgn, addr, wd, wt, last_rd, last_err, last_lat);
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wd, input int wt);
    logic [31:0] erd;
    logic        eerr;
    int          elat;
    model_req(we, sz, sgn, addr, wd, wt, erd, eerr, elat);
    run_req(we, sz, sgn, addr, wd, wt);
    check({tag, "_rdata"}, last_rd, erd);
    check({tag, "_err"}, 32'(last_err), 32'(eerr));
    check({tag, "_lat"}, last_lat, elat);
  endtask

  initial begin
    int   rd0, wr0, en0, g, resp_seen, lat;
    bit   ready_low_ok;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;

    // Byte loads, signed and unsigned
    set_word(1, 32'h12F45678);
    txn("lb_s", 1'b0, 2'b00, 1'b1, 32'h0000_1005, 32'h0, 0);
    check("lb_s_const", last_rd, 32'hFFFF_FFF4);
    check("lb_s_lat", last_lat, 2);
    txn("lb_u", 1'b0, 2'b00, 1'b0, 32'h0000_1005, 32'h0, 0);
    check("lb_u_const", last_rd, 32'h0000_00F4);

    // Sub-word stores as read-modify-write
    set_word(2, 32'h11223344);
    rd0 = n_rd; wr0 = n_wr;
    txn("sb", 1'b1, 2'b00, 1'b0, 32'h0000_100A, 32'h0000_00AB, 0);
    check("sb_wdata", last_wdata, 32'h1122_AB44);
    check("sb_lat3", last_lat, 3);
    check("sb_reads", n_rd - rd0, 1);
    check("sb_writes", n_wr - wr0, 1);
    check("sb_mem", dev_mem[2], 32'h1122_AB44);
    set_word(3, 32'h11223344);
    txn("sh", 1'b1, 2'b01, 1'b0, 32'h0000_100E, 32'h0000_BEEF, 0);
    check("sh_mem", dev_mem[3], 32'h1122_BEEF);
    set_word(4, 32'h80017777);
    txn("lh_s", 1'b0, 2'b01, 1'b1, 32'h0000_1010, 32'h0, 0);
    check("lh_s_const", last_rd, 32'hFFFF_8001);

    // Misaligned word load
    set_word(0, 32'hA1B2C3D4);
    en0 = n_en;
    txn("lw_mis", 1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 0);
`ifdef MEM_ALIGN_TRAP_EN
    check("lw_mis_trap_err", 32'(last_err), 32'd1);
    check("lw_mis_trap_lat", last_lat, 1);
    check("lw_mis_trap_noen", n_en - en0, 0);
`else
    check("lw_mis_addr", last_addr, 32'h0000_1000);
    check("lw_mis_word", last_rd, 32'hA1B2C3D4);
`endif

    // Doubleword is illegal at 32-bit width
    en0 = n_en;
    txn("ld_ill", 1'b0, 2'b11, 1'b1, 32'h0000_1000, 32'h0, 0);
    check("ld_ill_err", 32'(last_err), 32'd1);
    check("ld_ill_noen", n_en - en0, 0);

    // Slow memory with back-to-back requests: req_valid never drops
    set_word(5, 32'hCAFEBABE);
    set_word(6, 32'h01020304);
    wait_cfg = 3;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0000_1014; bus.req_wdata = 32'h0;
    @(posedge clk);
    #1;
    bus.req_addr = 32'h0000_1018;
    ready_low_ok = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.req_ready) ready_low_ok = 1'b0;
    end while (!bus.resp_valid && lat < 100);
    check("b2b_lat1", lat, 5);
    check("b2b_rdata1", bus.resp_rdata, 32'hCAFEBABE);
    check("b2b_ready_low", 32'(ready_low_ok), 32'd1);
    @(negedge clk);
    check("b2b_ready_after", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.resp_valid && lat < 100);
    check("b2b_lat2", lat, 5);
    check("b2b_rdata2", bus.resp_rdata, 32'h01020304);
    check("b2b_addr2", last_addr, 32'h0000_1018);

    // Reset in the write phase of a read-modify-write
    set_word(7, 32'h55667788);
    wait_cfg = 5;
    wr0 = n_wr;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0000_101D; bus.req_wdata = 32'h99;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    g = 0;
    while (!bus.mem_we && g < 50) begin @(negedge clk); g++; end
    check("rstwr_in_wr", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rstwr_en_drop", 32'(bus.mem_en), 32'd0);
    check("rstwr_we_drop", 32'(bus.mem_we), 32'd0);
    resp_seen = 0;
    repeat (2) begin @(negedge clk); if (bus.resp_valid) resp_seen++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.resp_valid) resp_seen++; end
    check("rstwr_no_resp", resp_seen, 0);
    check("rstwr_mem", dev_mem[7], 32'h55667788);
    check("rstwr_no_write", n_wr - wr0, 0);
    check("rstwr_ready", 32'(bus.req_ready), 32'd1);

    // Random accesses against the model
    for (int t = 0; t < 40; t++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      txn("rnd", 1'($urandom), sz, 1'($urandom), 32'h0000_1000 + 32'($urandom_range(0, 63)),
          $urandom, int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 16; i++) check("final_mem", dev_mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
